// File: rtl/cpu_isa_pkg.sv
// Instruction-set constants shared by the decoder and its neighbours.
// Holds opcode field masks/values, destination register codes, the default
// immediate source select and a helper that classifies an instruction word.
package cpu_isa_pkg;

    // Opcode match: (word & MASK) == VAL
    localparam logic [7:0] OP_LOAD_MASK = 8'h80;
    localparam logic [7:0] OP_LOAD      = 8'h00;
    localparam logic [7:0] OP_MOVE_MASK = 8'hC0;
    localparam logic [7:0] OP_MOVE      = 8'h80;
    localparam logic [7:0] OP_ALU_MASK  = 8'hE0;
    localparam logic [7:0] OP_ALU       = 8'hC0;
    localparam logic [7:0] OP_JMP_MASK  = 8'hF0;
    localparam logic [7:0] OP_JMP       = 8'hE0;
    localparam logic [7:0] OP_JNZ_MASK  = 8'hF0;
    localparam logic [7:0] OP_JNZ       = 8'hF0;

    // Destination register codes
    localparam logic [2:0] DST_X0 = 3'd0;
    localparam logic [2:0] DST_X1 = 3'd1;
    localparam logic [2:0] DST_Y0 = 3'd2;
    localparam logic [2:0] DST_Y1 = 3'd3;
    localparam logic [2:0] DST_O  = 3'd4;
    localparam logic [2:0] DST_M  = 3'd5;
    localparam logic [2:0] DST_I  = 3'd6;
    localparam logic [2:0] DST_R  = 3'd7;

    localparam logic [3:0] IMM_SRC_CODE_DEF = 4'h8;

    typedef enum logic [2:0] {
        ClsLoad,
        ClsMove,
        ClsAlu,
        ClsJmp,
        ClsJnz
    } instr_class_e;

    function automatic instr_class_e get_class(input logic [7:0] word);
        instr_class_e cls;
        if ((word & OP_LOAD_MASK) == OP_LOAD) begin
            cls = ClsLoad;
        end else if ((word & OP_MOVE_MASK) == OP_MOVE) begin
            cls = ClsMove;
        end else if ((word & OP_ALU_MASK) == OP_ALU) begin
            cls = ClsAlu;
        end else if ((word & OP_JMP_MASK) == OP_JMP) begin
            cls = ClsJmp;
        end else begin
            cls = ClsJnz;
        end
        return cls;
    endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Reset synchroniser: asserts asynchronously, releases synchronously.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-high reset
//   sync_reset out synchronised reset, drops on the SYNC_STAGES-th edge after release
module reset_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sync_reset
);

    logic [SYNC_STAGES-1:0] stages_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages_q <= '1;
        end else begin
            stages_q <= {stages_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_reset = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/instruction_decoder.sv
// Instruction decoder: turns the program-memory word into datapath and jump
// controls, keeps the zero flag and produces the sequencer's synchronised reset.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   pm_data[7:0]          instruction word
//   alu_zero              ALU result is zero (current cycle)
//   sync_reset            synchronised reset to the sequencer
//   jmp, jmp_nz           jump requests; jmp_addr[3:0] is the target
//   dont_jmp              current zero flag, suppresses jmp_nz in the sequencer
//   reg_en[7:0]           one-hot register load enables
//   source_sel[3:0]       datapath source select
//   data_imm[3:0]         immediate value
//   alu_func[3:0]         ALU function
//   zero_flag             registered zero flag
module instruction_decoder
    import cpu_isa_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [3:0]  IMM_SRC_CODE = IMM_SRC_CODE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pm_data,
    input  logic       alu_zero,
    output logic       sync_reset,
    output logic       jmp,
    output logic       jmp_nz,
    output logic [3:0] jmp_addr,
    output logic       dont_jmp,
    output logic [7:0] reg_en,
    output logic [3:0] source_sel,
    output logic [3:0] data_imm,
    output logic [3:0] alu_func,
    output logic       zero_flag
);

    instr_class_e cls;
    logic         zero_flag_q;
    logic [7:0]   one_hot_base;

    reset_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .reset      (reset),
        .sync_reset (sync_reset)
    );

    assign cls          = get_class(pm_data);
    assign one_hot_base = 8'h01;

    always_comb begin
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        reg_en     = 8'h00;
        source_sel = 4'h0;
        alu_func   = 4'h0;
        unique case (cls)
            ClsLoad: begin
                reg_en     = one_hot_base << pm_data[6:4];
                source_sel = IMM_SRC_CODE;
            end
            ClsMove: begin
                reg_en     = one_hot_base << pm_data[5:3];
                source_sel = {1'b0, pm_data[2:0]};
            end
            ClsAlu: begin
                reg_en   = one_hot_base << DST_R;
                alu_func = pm_data[3:0];
            end
            ClsJmp:  jmp    = 1'b1;
            ClsJnz:  jmp_nz = 1'b1;
            default: ;
        endcase
        // Sequencer and register file must see no activity until reset has settled.
        if (sync_reset) begin
            reg_en = 8'h00;
            jmp    = 1'b0;
            jmp_nz = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_flag_q <= 1'b0;
        end else if (!sync_reset && cls == ClsAlu) begin
            zero_flag_q <= alu_zero;
        end
    end

    assign zero_flag = zero_flag_q;
    assign dont_jmp  = zero_flag_q;
    assign jmp_addr  = pm_data[3:0];
    assign data_imm  = pm_data[3:0];

endmodule

// File: tb/tb_instruction_decoder.sv
module tb_instruction_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pm_data;
    logic       alu_zero;
    logic       sync_reset;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic [7:0] reg_en;
    logic [3:0] source_sel;
    logic [3:0] data_imm;
    logic [3:0] alu_func;
    logic       zero_flag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_decoder #(
        .SYNC_STAGES  (2),
        .IMM_SRC_CODE (4'h8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pm_data    (pm_data),
        .alu_zero   (alu_zero),
        .sync_reset (sync_reset),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .jmp_addr   (jmp_addr),
        .dont_jmp   (dont_jmp),
        .reg_en     (reg_en),
        .source_sel (source_sel),
        .data_imm   (data_imm),
        .alu_func   (alu_func),
        .zero_flag  (zero_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        pm_data  = 8'hE5;
        alu_zero = 1'b0;
        step();
        step();
        // 1: reset held, JMP on the bus must stay gated
        check("rst_sync_reset", sync_reset, 1);
        check("rst_jmp", jmp, 0);
        check("rst_reg_en", reg_en, 8'h00);
        check("rst_zero_flag", zero_flag, 0);
        check("rst_dont_jmp", dont_jmp, 0);
        check("rst_jmp_addr", jmp_addr, 4'h5);
        reset = 1'b0;
        #1;
        check("rel0_sync_reset", sync_reset, 1);
        step();
        check("rel1_sync_reset", sync_reset, 1);
        check("rel1_jmp", jmp, 0);
        step();
        check("rel2_sync_reset", sync_reset, 0);
        check("rel2_jmp", jmp, 1);

        // 2: LOAD and MOVE
        pm_data = 8'h3A; #1;
        check("load_reg_en", reg_en, 8'h08);
        check("load_src", source_sel, 4'h8);
        check("load_imm", data_imm, 4'hA);
        check("load_alu_func", alu_func, 4'h0);
        check("load_jmp", jmp, 0);
        pm_data = 8'h8B; #1;
        check("move_reg_en", reg_en, 8'h02);
        check("move_src", source_sel, 4'h3);
        pm_data = 8'hBF; #1;
        check("move7_reg_en", reg_en, 8'h80);
        check("move7_src", source_sel, 4'h7);
        pm_data = 8'h7F; #1;
        check("load7_reg_en", reg_en, 8'h80);
        check("load7_imm", data_imm, 4'hF);
        step();
        check("nonalu_zf", zero_flag, 0);

        // 3: ALU with zero result
        pm_data = 8'hC4; alu_zero = 1'b1; #1;
        check("alu_func", alu_func, 4'h4);
        check("alu_reg_en", reg_en, 8'h80);
        check("alu_src", source_sel, 4'h0);
        check("alu_zf_before", zero_flag, 0);
        step();
        check("alu_zf_after", zero_flag, 1);
        check("alu_dont_jmp", dont_jmp, 1);

        // 4: JNZ right after, then ALU non-zero
        pm_data = 8'hF7; alu_zero = 1'b0; #1;
        check("jnz_jmp_nz", jmp_nz, 1);
        check("jnz_jmp", jmp, 0);
        check("jnz_addr", jmp_addr, 4'h7);
        check("jnz_dont_jmp", dont_jmp, 1);
        check("jnz_reg_en", reg_en, 8'h00);
        step();
        check("jnz_zf_hold", zero_flag, 1);
        pm_data = 8'hD0; #1;
        step();
        check("alu_nz_dont_jmp", dont_jmp, 0);

        // 5: flag holds across a non-ALU op
        pm_data = 8'hC0; alu_zero = 1'b1; #1;
        step();
        check("set_zf", zero_flag, 1);
        pm_data = 8'h35; alu_zero = 1'b0; #1;
        check("hold_reg_en", reg_en, 8'h08);
        step();
        check("hold_zf", zero_flag, 1);

        // 6: asynchronous reset mid-run
        reset = 1'b1; #1;
        check("mid_zf", zero_flag, 0);
        check("mid_dont_jmp", dont_jmp, 0);
        check("mid_sync_reset", sync_reset, 1);
        check("mid_reg_en", reg_en, 8'h00);
        check("mid_imm", data_imm, 4'h5);
        step();
        reset = 1'b0;
        pm_data = 8'hC2; alu_zero = 1'b1; #1;
        step();
        // First edge after release: still in reset, flag must not update
        check("rel_gate_zf", zero_flag, 0);
        check("rel_gate_sync", sync_reset, 1);
        step();
        check("rel_done_sync", sync_reset, 0);
        check("rel_done_reg_en", reg_en, 8'h80);
        step();
        check("rel_done_zf", zero_flag, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
